// File: rtl/circuit_sweep_ctrl.sv
// circuit_sweep_ctrl: drives all 16 {A,B,C,D} vectors into the circuit
// G = B&C | ~A&~C&D in ascending order. Each vector is held for
// SETTLE_CYCLES clocks, then g_in is sampled and compared against the
// expected value. Vectors whose G toggled two or more times inside their
// window are counted as hazard glitches.
module circuit_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int GLITCH_W      = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                g_in,
  output logic                A,
  output logic                B,
  output logic                C,
  output logic                D,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [4:0]          err_count,
  output logic [3:0]          first_fail,
  output logic                first_fail_valid,
  output logic [GLITCH_W-1:0] glitch_vecs
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0]          CNT_LOAD  = 8'(SETTLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = {{(GLITCH_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [3:0]          idx_q;
  logic [7:0]          cnt_q;
  logic                g_prev_q;
  logic [1:0]          tog_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [4:0]          err_q;
  logic [3:0]          ff_q;
  logic                ffv_q;
  logic [GLITCH_W-1:0] glitch_q;

  logic                toggle;
  logic [1:0]          tog_d;
  logic                exp_g;
  logic                mism;
  logic [4:0]          err_d;
  logic [GLITCH_W-1:0] glitch_d;

  // Per-edge toggle accounting and sample-edge result updates
  always_comb begin
    toggle   = (g_in != g_prev_q);
    tog_d    = (toggle && (tog_q != 2'd2)) ? tog_q + 2'd1 : tog_q;
    exp_g    = (idx_q[2] & idx_q[1]) | (~idx_q[3] & ~idx_q[1] & idx_q[0]);
    mism     = (g_in != exp_g);
    err_d    = err_q + {4'd0, mism};
    glitch_d = ((tog_d == 2'd2) && (glitch_q != {GLITCH_W{1'b1}}))
               ? glitch_q + GLITCH_ONE : glitch_q;
  end

  // Sweep FSM: vector sequencing, settle timing and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      cnt_q    <= 8'd0;
      g_prev_q <= 1'b0;
      tog_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 5'd0;
      ff_q     <= 4'd0;
      ffv_q    <= 1'b0;
      glitch_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            err_q    <= 5'd0;
            ff_q     <= 4'd0;
            ffv_q    <= 1'b0;
            glitch_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            idx_q    <= 4'd0;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_LOAD;
            g_prev_q <= g_in;
            tog_q    <= 2'd0;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != 8'd0) begin
            cnt_q    <= cnt_q - 8'd1;
            tog_q    <= tog_d;
            g_prev_q <= g_in;
          end else begin
            err_q    <= err_d;
            glitch_q <= glitch_d;
            if (mism && !ffv_q) begin
              ff_q  <= idx_q;
              ffv_q <= 1'b1;
            end
            if (idx_q == 4'd15) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 5'd0);
              state_q <= DONE;
            end else begin
              idx_q    <= idx_q + 4'd1;
              cnt_q    <= CNT_LOAD;
              g_prev_q <= g_in;
              tog_q    <= 2'd0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign A                = idx_q[3];
  assign B                = idx_q[2];
  assign C                = idx_q[1];
  assign D                = idx_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;
  assign glitch_vecs      = glitch_q;

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Bench for circuit_sweep_ctrl: a behavioural circuit stand-in drives g_in
// from a truth table, optionally corrupted per vector, stuck, or pulsed.
// Expected results are derived from the corruption pattern by simple counting.
module tb_circuit_sweep_ctrl;

  localparam int SET = 4;
  localparam int GW  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          g_in;
  logic          A, B, C, D;
  logic          busy, done, pass;
  logic [4:0]    err_count;
  logic [3:0]    first_fail;
  logic          first_fail_valid;
  logic [GW-1:0] glitch_vecs;

  int checks = 0;
  int errors = 0;

  // Circuit stand-in controls
  logic [15:0] exp_ones;
  logic [15:0] inv_mask;
  logic [15:0] glitch_mask;
  int          mode;          // 0 truth table ^ inv_mask, 1 stuck-0, 2 stuck-1
  logic        pulse;
  logic [3:0]  vec;

  circuit_sweep_ctrl #(.SETTLE_CYCLES(SET), .GLITCH_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .g_in(g_in),
    .A(A), .B(B), .C(C), .D(D),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail),
    .first_fail_valid(first_fail_valid), .glitch_vecs(glitch_vecs)
  );

  always #5 clk = ~clk;

  assign vec = {A, B, C, D};

  always_comb begin
    g_in = 1'b0;
    if (mode == 1)      g_in = 1'b0 ^ pulse;
    else if (mode == 2) g_in = 1'b1 ^ pulse;
    else                g_in = exp_ones[vec] ^ inv_mask[vec] ^ pulse;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected results from the per-vector G values the stand-in presents
  task automatic ref_model(output int e_err, output int e_ff, output int e_ffv,
                           output int e_gl);
    logic g;
    e_err = 0; e_ff = 0; e_ffv = 0; e_gl = 0;
    for (int k = 0; k < 16; k++) begin
      if (mode == 1)      g = 1'b0;
      else if (mode == 2) g = 1'b1;
      else                g = exp_ones[k] ^ inv_mask[k];
      if (g != exp_ones[k]) begin
        e_err++;
        if (e_ffv == 0) begin
          e_ff  = k;
          e_ffv = 1;
        end
      end
      if (glitch_mask[k]) e_gl++;
    end
    if (e_gl > 31) e_gl = 31;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"},    32'(vec), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_done"},   32'(done), 32'd0);
    chk({tag, "_pass"},   32'(pass), 32'd0);
    chk({tag, "_err"},    32'(err_count), 32'd0);
    chk({tag, "_ff"},     32'(first_fail), 32'd0);
    chk({tag, "_ffv"},    32'(first_fail_valid), 32'd0);
    chk({tag, "_glitch"}, 32'(glitch_vecs), 32'd0);
  endtask

  // One sweep; abort_k >= 0 asserts reset while that vector is applied
  task automatic run_sweep(input string tag, input int abort_k, input bit hold);
    int busy_cnt;
    int e_err, e_ff, e_ffv, e_gl;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_done"}, 32'(done), 32'd0);
    chk({tag, "_start_err"},  32'(err_count), 32'd0);
    chk({tag, "_start_ffv"},  32'(first_fail_valid), 32'd0);
    busy_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < SET; c++) begin
        if (c == 0) chk({tag, "_vec"}, 32'(vec), 32'(k));
        if (busy) busy_cnt++;
        if (k == abort_k && c == 1) begin
          #2 rst_n = 1'b0;
          #1 chk_all_zero({tag, "_abort"});
          #2 rst_n = 1'b1;
          start = 1'b0;
          return;
        end
        if (glitch_mask[k[3:0]] && c == 1) pulse = 1'b1;
        if (c == 2) pulse = 1'b0;
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    ref_model(e_err, e_ff, e_ffv, e_gl);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(16 * SET));
    chk({tag, "_busy_end"},    32'(busy), 32'd0);
    chk({tag, "_done"},        32'(done), 32'd1);
    chk({tag, "_hold_vec"},    32'(vec), 32'd15);
    chk({tag, "_err"},         32'(err_count), 32'(e_err));
    chk({tag, "_ffv"},         32'(first_fail_valid), 32'(e_ffv));
    if (e_ffv != 0) chk({tag, "_ff"}, 32'(first_fail), 32'(e_ff));
    chk({tag, "_pass"},        32'(pass), 32'(e_err == 0));
    chk({tag, "_glitch"},      32'(glitch_vecs), 32'(e_gl));
  endtask

  initial begin
    exp_ones    = 16'hC0E2;   // G=1 at idx 1,5,6,7,14,15
    inv_mask    = 16'h0000;
    glitch_mask = 16'h0000;
    mode        = 0;
    pulse       = 1'b0;
    start       = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;

    run_sweep("golden", -1, 1'b0);

    mode = 1;
    run_sweep("stuck0", -1, 1'b0);
    chk("stuck0_err_abs", 32'(err_count), 32'd6);
    chk("stuck0_ff_abs",  32'(first_fail), 32'd1);

    mode = 0;
    run_sweep("after_stuck0", -1, 1'b0);

    mode = 2;
    run_sweep("stuck1", -1, 1'b0);
    chk("stuck1_err_abs", 32'(err_count), 32'd10);
    chk("stuck1_ff_abs",  32'(first_fail), 32'd0);

    mode = 0;
    glitch_mask = 16'h0080;
    run_sweep("glitch7", -1, 1'b0);
    chk("glitch7_abs", 32'(glitch_vecs), 32'd1);
    glitch_mask = 16'h0000;

    run_sweep("hold_start", -1, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("hold_start_no_restart", 32'(done), 32'd1);

    mode = 1;
    run_sweep("abort5", 5, 1'b0);
    mode = 0;
    run_sweep("after_abort", -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      inv_mask    = 16'($urandom);
      glitch_mask = 16'($urandom);
      run_sweep("random", -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
